// File: rtl/fft_sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: DEPTH-entry feedback line,
// sum/difference butterfly and fixed-point twiddle multiply, one complex sample per cycle.
module fft_sdf_bf_stage #(
  parameter int DW    = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_FILL = 2'd1,
    PH_BFLY = 2'd2,
    PH_RSVD = 2'd3
  } phase_t;

  // tag marks entries that hold a twiddled difference and must be emitted as valid
  typedef struct packed {
    logic                 tag;
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } entry_t;

  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + 1;

  phase_t phase;
  entry_t dl [DEPTH];
  entry_t head;
  entry_t push;

  logic signed [DW-1:0] x_r, x_i;
  logic signed [DW-1:0] sum_r, sum_i;
  logic signed [DW-1:0] dif_r, dif_i;
  logic signed [DW-1:0] ws_r, ws_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [AW-1:0] acc_r, acc_i;
  logic signed [DW-1:0] tw_r, tw_i;
  logic                 shift_en;

  assign phase    = phase_t'(state);
  assign head     = dl[0];
  assign shift_en = (phase == PH_FILL) || (phase == PH_BFLY);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x_r   = '0;
    x_i   = '0;
    if (in_valid) begin
      x_r = $signed(din_r);
      x_i = $signed(din_i);
    end
    ws_r  = $signed(w_r);
    ws_i  = $signed(w_i);

    sum_r = head.re + x_r;
    sum_i = head.im + x_i;
    dif_r = head.re - x_r;
    dif_i = head.im - x_i;

    // Full-precision products, sign-extended one bit before the add/sub.
    p_rr  = PW'(dif_r) * PW'(ws_r);
    p_ii  = PW'(dif_i) * PW'(ws_i);
    p_ri  = PW'(dif_r) * PW'(ws_i);
    p_ir  = PW'(dif_i) * PW'(ws_r);
    acc_r = AW'(p_rr) - AW'(p_ii);
    acc_i = AW'(p_ri) + AW'(p_ir);

    // Arithmetic shift floors toward minus infinity; the cast wraps to DW bits.
    tw_r  = DW'(acc_r >>> FRAC);
    tw_i  = DW'(acc_i >>> FRAC);

    push  = '{tag: 1'b0, re: x_r, im: x_i};
    if (phase == PH_BFLY) begin
      push = '{tag: 1'b1, re: tw_r, im: tw_i};
    end
  end

  // NOTE: the delay line is reset along with the outputs so the first fill after
  // reset pops cleared tags and never marks stale contents as valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl[i] <= '0;
      end
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        dl[i] <= dl[i+1];
      end
      dl[DEPTH-1] <= push;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      unique case (phase)
        PH_FILL: begin
          out_valid <= head.tag;
          dout_r    <= head.re;
          dout_i    <= head.im;
        end
        PH_BFLY: begin
          out_valid <= 1'b1;
          dout_r    <= sum_r;
          dout_i    <= sum_i;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// Directed bench for fft_sdf_bf_stage (DEPTH=2, FRAC=8): each scenario task drives a
// hand-computed vector table and compares dout/out_valid one clock after each state cycle.
module tb_fft_sdf_bf_stage;

  localparam int DW = 24;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] din_r, din_i;
  logic [1:0]    state;
  logic [DW-1:0] w_r, w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r, dout_i;

  int checks = 0;
  int errors = 0;

  fft_sdf_bf_stage #(.DW(DW), .FRAC(8), .DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one state cycle and sample 1 time unit after the capturing edge.
  task automatic drive(input int st, input int v, input int dr, input int di,
                       input int wr, input int wi);
    state    = st[1:0];
    in_valid = v[0];
    din_r    = DW'(dr);
    din_i    = DW'(di);
    w_r      = DW'(wr);
    w_i      = DW'(wi);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    state    = 2'd0;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    w_r      = '0;
    w_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom));
      checks++;
      if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got v=%b r=%h i=%h, want v=0 r=0 i=0",
                 i, out_valid, dout_r, dout_i);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, int'($urandom), int'($urandom), 0, 0);
      checks++;
      if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
        errors++;
        $display("FAIL reset_first_fill[%0d]: got v=%b r=%h i=%h, want v=0 r=0 i=0",
                 i, out_valid, dout_r, dout_i);
      end
    end
  endtask

  task automatic test_basic();
    int st[7] = '{1, 1, 2, 2, 1, 1, 0};
    int dr[7] = '{256, 512, 768, 1024, 0, 0, 0};
    int wr[7] = '{0, 0, 256, 0, 0, 0, 0};
    int wi[7] = '{0, 0, 0, -256, 0, 0, 0};
    int ev[7] = '{0, 0, 1, 1, 1, 1, 0};
    int er[7] = '{0, 0, 1024, 1536, -512, 0, 0};
    int ei[7] = '{0, 0, 0, 0, 0, 512, 512};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(st[i], 1, dr[i], 0, wr[i], wi[i]);
      checks++;
      if (out_valid !== ev[i][0] || dout_r !== DW'(er[i]) || dout_i !== DW'(ei[i])) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b r=%h i=%h, want v=%0d r=%h i=%h",
                 i, out_valid, dout_r, dout_i, ev[i], DW'(er[i]), DW'(ei[i]));
      end
    end
  endtask

  task automatic test_hold();
    int st[9] = '{1, 1, 2, 0, 0, 0, 2, 1, 1};
    int dr[9] = '{256, 512, 768, 999, 999, 999, 1024, 0, 0};
    int wr[9] = '{0, 0, 256, 77, 77, 77, 0, 0, 0};
    int wi[9] = '{0, 0, 0, 77, 77, 77, -256, 0, 0};
    int ev[9] = '{0, 0, 1, 0, 0, 0, 1, 1, 1};
    int er[9] = '{0, 0, 1024, 1024, 1024, 1024, 1536, -512, 0};
    int ei[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 512};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(st[i], 1, dr[i], 0, wr[i], wi[i]);
      checks++;
      if (out_valid !== ev[i][0] || dout_r !== DW'(er[i]) || dout_i !== DW'(ei[i])) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b r=%h i=%h, want v=%0d r=%h i=%h",
                 i, out_valid, dout_r, dout_i, ev[i], DW'(er[i]), DW'(ei[i]));
      end
    end
  endtask

  // (0-1)*128>>8 and (0-1j)*128>>8 both floor to -1.
  task automatic test_floor();
    int st[6] = '{1, 1, 2, 2, 1, 1};
    int dr[6] = '{0, 0, 1, 0, 0, 0};
    int di[6] = '{0, 0, 0, 1, 0, 0};
    int wr[6] = '{0, 0, 128, 128, 0, 0};
    int ev[6] = '{0, 0, 1, 1, 1, 1};
    int er[6] = '{0, 0, 1, 0, -1, 0};
    int ei[6] = '{0, 0, 0, 1, 0, -1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(st[i], 1, dr[i], di[i], wr[i], 0);
      checks++;
      if (out_valid !== ev[i][0] || dout_r !== DW'(er[i]) || dout_i !== DW'(ei[i])) begin
        errors++;
        $display("FAIL floor[%0d]: got v=%b r=%h i=%h, want v=%0d r=%h i=%h",
                 i, out_valid, dout_r, dout_i, ev[i], DW'(er[i]), DW'(ei[i]));
      end
    end
  endtask

  // Wrap of the sum, zero flush with in_valid=0, and state 3 acting as idle.
  task automatic test_wrap();
    int st[7] = '{1, 1, 2, 2, 3, 1, 1};
    int v[7]  = '{1, 1, 1, 0, 1, 1, 1};
    int dr[7] = '{8388607, 0, 1, 5, 7, 0, 0};
    int di[7] = '{0, 0, 0, 5, 7, 0, 0};
    int wr[7] = '{0, 0, 256, 256, 0, 0, 0};
    int ev[7] = '{0, 0, 1, 1, 0, 1, 1};
    int er[7] = '{0, 0, 8388608, 0, 0, 8388606, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(st[i], v[i], dr[i], di[i], wr[i], 0);
      checks++;
      if (out_valid !== ev[i][0] || dout_r !== DW'(er[i]) || dout_i !== '0) begin
        errors++;
        $display("FAIL wrap[%0d]: got v=%b r=%h i=%h, want v=%0d r=%h i=0",
                 i, out_valid, dout_r, dout_i, ev[i], DW'(er[i]));
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    drive(1, 1, 256, 0, 0, 0);
    drive(1, 1, 512, 0, 0, 0);
    drive(2, 1, 768, 0, 256, 0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== DW'(1024)) begin
      errors++;
      $display("FAIL midreset_pre: got v=%b r=%h, want v=1 r=%h", out_valid, dout_r, DW'(1024));
    end
    state = 2'd2;
    din_r = DW'(1024);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
      errors++;
      $display("FAIL midreset_async: got v=%b r=%h i=%h, want v=0 r=0 i=0",
               out_valid, dout_r, dout_i);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
      errors++;
      $display("FAIL midreset_edge: got v=%b r=%h i=%h, want v=0 r=0 i=0",
               out_valid, dout_r, dout_i);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 300 + i, 40, 0, 0);
      checks++;
      if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0) begin
        errors++;
        $display("FAIL midreset_after[%0d]: got v=%b r=%h i=%h, want v=0 r=0 i=0",
                 i, out_valid, dout_r, dout_i);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b1;
    state    = 2'd0;
    in_valid = 1'b0;
    din_r    = '0;
    din_i    = '0;
    w_r      = '0;
    w_i      = '0;
    #2;
    test_reset();
    test_basic();
    test_hold();
    test_floor();
    test_wrap();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_sdf_bf_stage.md
Name: fft_sdf_bf_stage

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the 32-point FFT pipeline.
- Sits directly downstream of the stage twiddle ROM and consumes its state[1:0], w_r and w_i outputs.
- Uses a DEPTH-entry feedback delay line for the sum/difference butterfly and the complex twiddle multiply.
- Emits one complex sample per active cycle to the next stage.

Parameters:
- DW, 24, signed two's-complement data/twiddle width, fixed point with FRAC fraction bits (1.0 = 256)
- FRAC, 8, fraction bits of the twiddle format
- DEPTH, 2, feedback delay length (N/2^k for this stage); state holds 1 and holds 2 each last DEPTH cycles

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  din_r/din_i carry a valid sample this cycle
- din_r  input  DW  input sample, real
- din_i  input  DW  input sample, imaginary
- state  input  2  phase from twiddle ROM: 0 = idle/hold, 1 = fill/forward, 2 = butterfly, 3 = treated as 0
- w_r  input  DW  twiddle, real (valid while state==2)
- w_i  input  DW  twiddle, imaginary (valid while state==2)
- out_valid  output  1  dout carries a valid sample
- dout_r  output  DW  output sample, real (registered)
- dout_i  output  DW  output sample, imaginary (registered)

Behaviour:
- Single clock, reset is asynchronous and active-low.
- Reset (reset_n=0): dout_r=0, dout_i=0, out_valid=0. All delay entries and their tags are cleared to 0. Reset takes effect immediately, including mid-frame.
- Effective input x = din if in_valid=1, else 0+0j. This provides a zero flush while the ROM keeps sequencing.
- Delay line: DEPTH-entry shift register with head = oldest entry. Each entry holds a complex value plus a 1-bit tag. It shifts only when state is 1 or 2.
- state 0 or 3:
  - Delay line frozen.
  - out_valid<=0 next cycle; dout holds its last value.
- state 1 (fill/forward):
  - Push x with tag=0.
  - Pop head; register dout<=head.
  - out_valid<=head.tag.
- state 2 (butterfly):
  - dout<=head + x; out_valid<=1.
  - Push (head - x)*w with tag=1.
- Latency: dout/out_valid appear one clock after the driving state cycle.
- Arithmetic:
  - Add/sub are DW-bit with two's-complement wrap, no saturation.
  - Complex multiply uses full-precision products, (2*DW+1)-bit sums:
    - re = a_r*w_r - a_i*w_i
    - im = a_r*w_i + a_i*w_r
  - Arithmetic shift right by FRAC (floor rounding), then truncate to low DW bits (wrap).
- Output order per 2*DEPTH-cycle block: DEPTH sums, then during the next state-1 hold DEPTH twiddled differences.
- Tags make the first state-1 hold after reset emit out_valid=0 (no garbage).
- A state change to 0 mid-hold freezes all content; resuming continues exactly where it stopped.
- Simultaneous reset and active state: reset wins.

Test Plan:
- Reset: hold reset_n=0 with random din/state -> dout_r=dout_i=0, out_valid=0; release with state=1 for 2 cycles -> out_valid stays 0.
- Basic butterfly (DEPTH=2):
  - Stimulus: state 1,1,2,2,1,1; din_r = 256, 512, 768, 1024, 0, 0 (imag 0, in_valid=1).
  - Twiddles: w = 256+0j on the 1st state-2 cycle, 0+(-256)j (w_i=0xFFFF00) on the 2nd.
  - Required: out_valid high on cycles 5-8, dout = 1024+0j, 1536+0j, -512+0j, 0+512j.
- Hold: insert 3 cycles of state=0 between the two state-2 cycles of the basic test -> out_valid=0 during the hold; output sequence values unchanged.
- Floor rounding: head=0, x=1, w=128+0j -> twiddled difference emitted in the next state-1 hold = -1+0j.
- Wrap: head=0x7FFFFF, x=1 (real) in state 2 -> sum output 0x800000 (no saturation).
- Mid-frame reset: assert reset_n=0 during state 2, release, run state 1,1 -> out_valid=0, dout=0 throughout.
